// File: rtl/pulse_stretcher_multi.sv
// Multi-channel pulse stretcher with per-channel edge select, retrigger mode and saturating event counters.
// Define STRETCH_SYNC_EN to insert a 2-flop synchroniser on every input (3-cycle latency instead of 1).
module pulse_stretcher_multi #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16,
  parameter int EVT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           in_sig,
  input  logic [CHANNELS-1:0]           edge_sel,
  input  logic [CHANNELS-1:0]           retrig_en,
  input  logic [CNT_WIDTH-1:0]          stretch_len,
  input  logic                          count_clr,
  output logic [CHANNELS-1:0]           out_sig,
  output logic [CHANNELS*EVT_WIDTH-1:0] evt_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [EVT_WIDTH-1:0] EVT_ONE = EVT_WIDTH'(1);

  logic [CHANNELS-1:0] cur;
  logic [CHANNELS-1:0] prev;
  logic [CHANNELS-1:0] trigger;
  logic                len_nz;

`ifdef STRETCH_SYNC_EN
  logic [CHANNELS-1:0] sync_a;
  logic [CHANNELS-1:0] sync_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= in_sig;
      sync_b <= sync_a;
    end
  end

  assign cur = sync_b;
`else
  assign cur = in_sig;
`endif

  // prev is cleared by reset, so a line held high through reset yields one rising edge afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= cur;
    end
  end

  assign trigger = (edge_sel & prev & ~cur) | (~edge_sel & ~prev & cur);
  assign len_nz  = |stretch_len;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [EVT_WIDTH-1:0] evt;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
      end
    end

    // A retrigger reloads even in the final (cnt == 0) cycle; without retrigger that trigger is lost.
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
        IDLE: begin
          if (trigger[i] && len_nz) begin
            state_next = ACTIVE;
            cnt_next   = stretch_len - CNT_ONE;
          end
        end
        ACTIVE: begin
          if (trigger[i] && retrig_en[i] && len_nz) begin
            cnt_next = stretch_len - CNT_ONE;
          end else if (cnt == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst || count_clr) begin
        evt <= '0;
      end else if (trigger[i] && (evt != '1)) begin
        evt <= evt + EVT_ONE;
      end
    end

    assign out_sig[i]                             = (state == ACTIVE);
    assign evt_count[i*EVT_WIDTH +: EVT_WIDTH]    = evt;
  end

endmodule

// File: doc/pulse_stretcher_multi.md
# pulse_stretcher_multi

Multi-channel, parametrised successor to the single-channel stretcher. It stretches short pulses on the PLL monitor, camera monitor and spare trigger lines into fixed-width output pulses. Each channel has its own runtime edge-select and retrigger mode, plus a saturating event counter readable by the serial GPIO register file. It sits in the top level between the raw pins and the output/LED drivers, on the main system clock.

## Interface
- CHANNELS, 4, number of independent channels (1..16)
- CNT_WIDTH, 16, width of the stretch-length counter
- EVT_WIDTH, 8, width of each per-channel event counter
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_sig  in  CHANNELS  raw asynchronous pulse inputs
- edge_sel  in  CHANNELS  per channel: 0 = trigger on rising edge, 1 = trigger on falling edge
- retrig_en  in  CHANNELS  per channel: 1 = a trigger while active restarts the pulse
- stretch_len  in  CNT_WIDTH  output pulse length in clk cycles, shared by all channels, sampled at each accepted trigger
- count_clr  in  1  synchronous clear of all event counters
- out_sig  out  CHANNELS  stretched outputs, registered
- evt_count  out  CHANNELS*EVT_WIDTH  per-channel detected-edge counts; channel i at bits [i*EVT_WIDTH +: EVT_WIDTH]

## Operation
- Per channel:
  - input path: optional 2-flop synchroniser, then a registered previous-value flop (prev).
  - trigger = selected edge between the current (synchronised) value and prev.
- Per-channel FSM, IDLE / ACTIVE, with down-counter cnt[CNT_WIDTH]:
  - IDLE, trigger, stretch_len > 0: out=1, cnt=stretch_len-1, go ACTIVE.
  - IDLE, trigger, stretch_len == 0: trigger ignored, out stays 0; the event is still counted.
  - ACTIVE, cnt > 0, no accepted retrigger: cnt decrements, out stays 1.
  - ACTIVE, cnt == 0, no accepted retrigger: out=0, go IDLE.
  - ACTIVE, trigger, retrig_en=1, stretch_len > 0: cnt=stretch_len-1, out stays 1. This applies in every ACTIVE cycle, including the final one (cnt==0).
  - ACTIVE, trigger, retrig_en=0: trigger dropped, FSM unaffected. A trigger in the final active cycle is also dropped, so out goes low for at least one cycle.
  - ACTIVE, trigger, retrig_en=1, stretch_len == 0: treated as no trigger.
- A stretch_len change while ACTIVE does not affect the running count.
- Changing edge_sel or retrig_en takes effect on the next cycle's edge comparison.
- Event counter:
  - increments on every detected edge, accepted or not;
  - saturates at 2^EVT_WIDTH-1, no wrap;
  - count_clr wins over a simultaneous increment (result 0).
- Channels are fully independent. Simultaneous triggers on several channels are all serviced in the same cycle.

## Timing
- Reset: out_sig=0, evt_count=0, all FSMs IDLE, cnt=0, synchroniser and prev flops=0. Reset asserted mid-pulse terminates the pulse on the next edge.
- Consequence of the zero-cleared flops: an input held high across reset release produces one rising-edge trigger after reset; falling-edge channels do not trigger.
- Latency, with synchroniser: input change before clk edge k → out_sig high after edge k+2.
- Latency, without synchroniser: out_sig high after edge k.
- Pulse width is exactly stretch_len cycles when no retrigger occurs.
- With a retrigger, out stays high for stretch_len cycles counted from the retrigger's register edge.
- evt_count updates on the same edge that out_sig responds.
- No combinational paths from inputs to outputs.

## Configuration
- STRETCH_SYNC_EN defined: each in_sig passes through a 2-flop synchroniser. Latency is 3 cycles; use for asynchronous pins.
- STRETCH_SYNC_EN undefined: in_sig feeds the edge detector directly. Latency is 1 cycle; only for inputs already synchronous to clk.

## Test plan
- Rising-edge pulse: stretch_len=10, ch0 rising, 1-cycle pulse → out_sig[0] high exactly 10 cycles; latency 3 (sync) / 1 (no sync); evt_count ch0 = 1.
- Retrigger: stretch_len=10, retrig_en[1]=1, second pulse 6 cycles after the first → out_sig[1] continuous high for 16 cycles; count 2.
- No retrigger: same stimulus, retrig_en=0 → high 10 cycles only; count 2. A trigger in the final active cycle → out low for ≥1 cycle.
- Falling edge and zero length:
  - edge_sel[2]=1: high→low transition → 10-cycle pulse; low→high transition → none.
  - stretch_len=0: no pulse, count still increments.
- Counter saturation and clear: 300 pulses on ch3 with EVT_WIDTH=8 → count 255. count_clr asserted with a simultaneous edge → 0.
- Reset:
  - rst mid-pulse → out_sig=0 next cycle, counts 0.
  - input held high through reset release → exactly one rising trigger.
